weight_buffer_pp: RTL and testbench
===================================

Name: weight_buffer_pp

Overview:
- Parametrised, double-buffered (ping-pong) weight cache feeding the PE array: NUM_KERNEL kernels × NUM_RDATA positions × NUM_CHANNEL channels.
- The loader fills one bank while the array reads the other, so there are no stall cycles between weight sets.
- Sits between the weight DMA/loader and the conv PE array.
- Adds ready/backpressure, explicit bank release, and a dropped-request flag.

Parameters:
- DAT_WIDTH, 8: bits per weight element.
- NUM_KERNEL, 4: kernels buffered in parallel (≥1).
- NUM_CHANNEL, 3: channels per input word (≥1).
- NUM_RDATA, 3: positions (words) per kernel per bank (≥1).
- CNT_W, $clog2(NUM_RDATA+1): width of each fill counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_data  in  NUM_KERNEL*NUM_CHANNEL*DAT_WIDTH  one word per kernel; kernel k occupies slice k.
- i_data_val  in  NUM_KERNEL  per-kernel write strobe.
- o_wr_rdy  out  NUM_KERNEL  kernel k may accept a word this cycle.
- i_data_req  in  1  read request from the PE array.
- o_data  out  NUM_KERNEL*NUM_RDATA*NUM_CHANNEL*DAT_WIDTH  registered weight set.
- o_data_val  out  1  o_data is valid (single-cycle pulse).
- i_release  in  1  PE array has finished with the current read bank.
- o_rd_rdy  out  1  the read bank is FULL.
- o_full  out  1  both banks are FULL.
- o_empty  out  1  both banks are EMPTY.
- o_req_drop  out  1  one-cycle pulse when i_data_req arrives while o_rd_rdy=0.

Behaviour:
- Storage: 2 banks × NUM_KERNEL × NUM_RDATA words, each NUM_CHANNEL*DAT_WIDTH bits wide. Each bank has one fill counter per kernel, range 0..NUM_RDATA.
- Bank state (derived from the counters):
  - EMPTY: all counters are 0.
  - FULL: all counters equal NUM_RDATA.
  - FILL: any other combination.
- Pointers: wr_sel and rd_sel, both 1 bit. Banks are consumed in fill order.
- Reset (rst=0, async): all counters 0, wr_sel=rd_sel=0, o_data=0. o_data_val, o_req_drop and o_full are 0; o_empty=1, o_rd_rdy=0. Storage contents need not be cleared.
- Write:
  - o_wr_rdy[k] = (count[wr_sel][k] < NUM_RDATA).
  - When i_data_val[k] and o_wr_rdy[k] are both 1, the word is stored at slot count[wr_sel][k] and the counter increments.
  - When i_data_val[k]=1 and o_wr_rdy[k]=0, the word is silently dropped and no state changes.
  - Kernels fill independently and in any order.
- wr_sel toggle: on the clock edge where the registered state of bank wr_sel is FULL and bank !wr_sel is EMPTY. Until that edge, every o_wr_rdy bit is 0.
- Read:
  - o_rd_rdy = (bank rd_sel is FULL).
  - When i_data_req=1 and o_rd_rdy=1: on the next edge o_data is loaded from bank rd_sel and o_data_val=1 for exactly one cycle. Latency is 1 cycle.
  - The bank is not consumed by a request, so repeated requests re-read the same set (weight reuse).
- Output packing, per kernel: slot NUM_RDATA-1 (last written) in the MSBs down to slot 0 in the LSBs. Kernel k occupies slice k of o_data.
- Dropped request: i_data_req=1 with o_rd_rdy=0 → no data, o_data_val=0, o_req_drop=1 on the next cycle.
- Release:
  - i_release=1 with o_rd_rdy=1 → all counters of bank rd_sel clear and rd_sel toggles, on the same edge.
  - i_release with o_rd_rdy=0 is ignored.
- i_data_req and i_release in the same cycle: the request is served first (o_data captures the old bank), then the bank is released. o_data stays stable until the next accepted request.
- Release of bank X in the same cycle that the write bank becomes FULL: wr_sel toggles one cycle later, because the toggle is evaluated on registered state.
- Status flags:
  - o_full = both banks FULL.
  - o_empty = both banks EMPTY.
  - Both are combinational from registered state.
- rst asserted mid-operation: all buffered sets are discarded immediately; any in-flight o_data_val is cleared.

Test Plan:
1. Reset, defaults (4/3/3/8): hold rst=0, then release → o_empty=1, o_wr_rdy=4'b1111, o_rd_rdy=0. Then drive i_data_req=1 → o_req_drop=1 next cycle, o_data_val=0.
2. Single fill/read: write words 0x010203, 0x040506, 0x070809 to kernel 0, and similar distinct words to kernels 1–3, writing kernels in differing orders → o_rd_rdy=1. Then i_data_req → o_data_val one cycle later; the kernel 0 slice equals 0x070809_040506_010203.
3. Ping-pong: fill bank 0, then keep writing set B → set B goes to bank 1 with no stall. Read, then release → the next read returns set B. o_full=1 while both sets are resident.
4. Backpressure: with both banks FULL, drive i_data_val=4'hF → o_wr_rdy=0 and the data is dropped. After i_release, writes are accepted again into the released bank on the following cycles.
5. Simultaneous events: i_data_req and i_release in the same cycle → o_data=set A with o_data_val=1, while rd_sel advances to set B. Also drive a release in the same cycle that the write bank completes → wr_sel toggles exactly one cycle later.
6. Async reset mid-fill: assert rst between clock edges with 2 words loaded → outputs go to reset values immediately, without waiting for a clock edge, and a subsequent full 3-word fill reads back correctly. Repeat test 2 with NUM_KERNEL=2, NUM_CHANNEL=4, NUM_RDATA=5, DAT_WIDTH=16.

Source files
------------

// File: rtl/weight_buffer_pp.sv
// Ping-pong weight cache between the weight loader and the PE array: one bank fills while
// the other is read, and banks retire in fill order on an explicit release.
module weight_buffer_pp #(
   parameter int DAT_WIDTH   = 8,
   parameter int NUM_KERNEL  = 4,
   parameter int NUM_CHANNEL = 3,
   parameter int NUM_RDATA   = 3,
   parameter int CNT_W       = $clog2(NUM_RDATA + 1)
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic [NUM_KERNEL*NUM_CHANNEL*DAT_WIDTH-1:0]           i_data,
   input  logic [NUM_KERNEL-1:0]                              i_data_val,
   output logic [NUM_KERNEL-1:0]                              o_wr_rdy,
   input  logic                                               i_data_req,
   output logic [NUM_KERNEL*NUM_RDATA*NUM_CHANNEL*DAT_WIDTH-1:0] o_data,
   output logic                                               o_data_val,
   input  logic                                               i_release,
   output logic                                               o_rd_rdy,
   output logic                                               o_full,
   output logic                                               o_empty,
   output logic                                               o_req_drop
);

   localparam int WORD_W = NUM_CHANNEL * DAT_WIDTH;
   localparam int SET_W  = NUM_KERNEL * NUM_RDATA * WORD_W;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_RDATA);

   logic [1:0][NUM_KERNEL-1:0][NUM_RDATA-1:0][WORD_W-1:0] mem;
   logic [1:0][NUM_KERNEL-1:0][CNT_W-1:0]                 cnt;
   logic [1:0][NUM_KERNEL-1:0]                            kern_full;
   logic [1:0][NUM_KERNEL-1:0]                            kern_empty;
   logic [1:0]                                            bank_full;
   logic [1:0]                                            bank_empty;

   logic                  wr_sel;
   logic                  rd_sel;
   logic [NUM_KERNEL-1:0] wr_acc;
   logic                  rd_acc;
   logic                  rel_acc;
   logic                  wr_toggle;

   logic [SET_W-1:0]      data_p1;
   logic                  vld_p1;
   logic                  drop_p1;

   // Fill counters and word storage, one counter per bank and kernel
   genvar b, k, s;
   for (b = 0; b < 2; b++) begin : g_bank
      for (k = 0; k < NUM_KERNEL; k++) begin : g_ker
         logic [CNT_W-1:0] cnt_q;
         logic             we;

         assign we = wr_acc[k] && (wr_sel == 1'(b));

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               cnt_q <= '0;
            end else if (rel_acc && (rd_sel == 1'(b))) begin
               cnt_q <= '0;
            end else if (we) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end

         assign cnt[b][k]        = cnt_q;
         assign kern_full[b][k]  = (cnt_q == CNT_MAX);
         assign kern_empty[b][k] = (cnt_q == '0);

         for (s = 0; s < NUM_RDATA; s++) begin : g_slot
            logic [WORD_W-1:0] word_q;

            always_ff @(posedge clk) begin
               if (we && (cnt_q == CNT_W'(s))) begin
                  word_q <= i_data[k*WORD_W +: WORD_W];
               end
            end

            assign mem[b][k][s] = word_q;
         end
      end

      assign bank_full[b]  = &kern_full[b];
      assign bank_empty[b] = &kern_empty[b];
   end

   for (k = 0; k < NUM_KERNEL; k++) begin : g_wr_rdy
      assign o_wr_rdy[k] = (cnt[wr_sel][k] < CNT_MAX);
   end

   assign wr_acc    = i_data_val & o_wr_rdy;
   assign o_rd_rdy  = bank_full[rd_sel];
   assign rd_acc    = i_data_req & o_rd_rdy;
   assign rel_acc   = i_release & o_rd_rdy;
   // Evaluated on registered counters, so a release landing on the completing edge delays the toggle by one cycle
   assign wr_toggle = bank_full[wr_sel] & bank_empty[~wr_sel];
   assign o_full    = &bank_full;
   assign o_empty   = &bank_empty;

   // p1: registered read port, captures the read bank before any same-edge release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         vld_p1  <= 1'b0;
         drop_p1 <= 1'b0;
         data_p1 <= '0;
      end else begin
         if (wr_toggle) begin
            wr_sel <= ~wr_sel;
         end
         if (rel_acc) begin
            rd_sel <= ~rd_sel;
         end
         vld_p1  <= rd_acc;
         drop_p1 <= i_data_req & ~o_rd_rdy;
         if (rd_acc) begin
            data_p1 <= mem[rd_sel];
         end
      end
   end

   assign o_data     = data_p1;
   assign o_data_val = vld_p1;
   assign o_req_drop = drop_p1;

endmodule

// File: tb/tb_weight_buffer_pp.sv
// Bench for weight_buffer_pp: queue-of-sets reference model checked every cycle, plus
// directed scenarios with literal expectations and a second parameter set.
module tb_weight_buffer_pp;

   localparam int DW  = 8;
   localparam int NK  = 4;
   localparam int NC  = 3;
   localparam int NR  = 3;
   localparam int CW  = NC * DW;
   localparam int OW  = NK * NR * CW;

   localparam int BDW = 16;
   localparam int BNK = 2;
   localparam int BNC = 4;
   localparam int BNR = 5;
   localparam int BCW = BNC * BDW;
   localparam int BOW = BNK * BNR * BCW;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [NK*CW-1:0] i_data;
   logic [NK-1:0]    i_data_val;
   logic [NK-1:0]    o_wr_rdy;
   logic             i_data_req;
   logic [OW-1:0]    o_data;
   logic             o_data_val;
   logic             i_release;
   logic             o_rd_rdy;
   logic             o_full;
   logic             o_empty;
   logic             o_req_drop;

   logic [BNK*BCW-1:0] b_data;
   logic [BNK-1:0]     b_data_val;
   logic [BNK-1:0]     b_wr_rdy;
   logic               b_data_req;
   logic [BOW-1:0]     b_odata;
   logic               b_odata_val;
   logic               b_release;
   logic               b_rd_rdy;
   logic               b_full;
   logic               b_empty;
   logic               b_req_drop;

   weight_buffer_pp #(.DAT_WIDTH(DW), .NUM_KERNEL(NK), .NUM_CHANNEL(NC), .NUM_RDATA(NR)) u_dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_data_val(i_data_val), .o_wr_rdy(o_wr_rdy),
      .i_data_req(i_data_req), .o_data(o_data), .o_data_val(o_data_val), .i_release(i_release),
      .o_rd_rdy(o_rd_rdy), .o_full(o_full), .o_empty(o_empty), .o_req_drop(o_req_drop)
   );

   weight_buffer_pp #(.DAT_WIDTH(BDW), .NUM_KERNEL(BNK), .NUM_CHANNEL(BNC), .NUM_RDATA(BNR)) u_dut_b (
      .clk(clk), .rst(rst), .i_data(b_data), .i_data_val(b_data_val), .o_wr_rdy(b_wr_rdy),
      .i_data_req(b_data_req), .o_data(b_odata), .o_data_val(b_odata_val), .i_release(b_release),
      .o_rd_rdy(b_rd_rdy), .o_full(b_full), .o_empty(b_empty), .o_req_drop(b_req_drop)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: completed sets queue in fill order; the set being filled is kept per kernel;
   // 'pending' marks a just-completed set that still owns the write side.
   logic [OW-1:0] done_q[$];
   int            part_n[NK];
   logic [CW-1:0] part_w[NK][NR];
   bit            pending;
   logic          exp_val;
   logic          exp_drop;
   logic [OW-1:0] exp_data;

   task automatic model_reset();
      done_q.delete();
      for (int k = 0; k < NK; k++) part_n[k] = 0;
      pending  = 1'b0;
      exp_val  = 1'b0;
      exp_drop = 1'b0;
      exp_data = '0;
   endtask

   task automatic model_step();
      bit            rdy;
      bit            pend0;
      int            sz0;
      bit            all_full;
      logic [OW-1:0] set_v;
      rdy   = (done_q.size() > 0);
      pend0 = pending;
      sz0   = done_q.size();
      exp_val  = i_data_req && rdy;
      exp_drop = i_data_req && !rdy;
      if (i_data_req && rdy) exp_data = done_q[0];
      for (int k = 0; k < NK; k++) begin
         if (i_data_val[k] && !pend0 && part_n[k] < NR) begin
            part_w[k][part_n[k]] = i_data[k*CW +: CW];
            part_n[k]++;
         end
      end
      if (i_release && rdy) void'(done_q.pop_front());
      if (pend0 && sz0 == 1) pending = 1'b0;
      all_full = 1'b1;
      for (int k = 0; k < NK; k++) if (part_n[k] != NR) all_full = 1'b0;
      if (all_full) begin
         set_v = '0;
         for (int k = 0; k < NK; k++)
            for (int s = 0; s < NR; s++)
               set_v[(k*NR+s)*CW +: CW] = part_w[k][s];
         done_q.push_back(set_v);
         pending = 1'b1;
         for (int k = 0; k < NK; k++) part_n[k] = 0;
      end
   endtask

   always @(negedge rst) model_reset();

   always @(posedge clk) begin
      if (rst === 1'b1) model_step();
   end

   always @(negedge clk) begin
      logic [NK-1:0] wr_exp;
      bit            emp;
      emp = (done_q.size() == 0);
      for (int k = 0; k < NK; k++) begin
         wr_exp[k] = !pending && (part_n[k] < NR);
         if (part_n[k] != 0) emp = 1'b0;
      end
      chk("wr_rdy",   1024'(o_wr_rdy),   1024'(wr_exp));
      chk("rd_rdy",   1024'(o_rd_rdy),   1024'(done_q.size() > 0));
      chk("full",     1024'(o_full),     1024'(done_q.size() == 2));
      chk("empty",    1024'(o_empty),    1024'(emp));
      chk("data_val", 1024'(o_data_val), 1024'(exp_val));
      chk("req_drop", 1024'(o_req_drop), 1024'(exp_drop));
      chk("data",     1024'(o_data),     1024'(exp_data));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [CW-1:0] wa(input int k, input int s);
      int v;
      v = k*9 + s*3 + 1;
      return {8'(v), 8'(v+1), 8'(v+2)};
   endfunction

   task automatic wr_word(input int k, input logic [CW-1:0] w);
      i_data_val = '0;
      i_data[k*CW +: CW] = w;
      i_data_val[k] = 1'b1;
      tick();
      i_data_val = '0;
   endtask

   task automatic fill_slots(input logic [7:0] tag, input int s0, input int s1);
      for (int s = s0; s <= s1; s++) begin
         i_data_val = '1;
         for (int k = 0; k < NK; k++) i_data[k*CW +: CW] = {tag, 8'(k), 8'(s)};
         tick();
      end
      i_data_val = '0;
   endtask

   task automatic pulse_req();
      i_data_req = 1'b1;
      tick();
      i_data_req = 1'b0;
   endtask

   function automatic logic [BCW-1:0] wbk(input int k, input int s);
      return {16'(k), 16'(s), 16'hA5A5, 16'(k*16 + s)};
   endfunction

   int            kc[NK];
   int            bkc[BNK];
   int            order[12];
   int            sched[10];
   logic [BOW-1:0] exp_b;

   initial begin
      model_reset();
      i_data = '0; i_data_val = '0; i_data_req = 1'b0; i_release = 1'b0;
      b_data = '0; b_data_val = '0; b_data_req = 1'b0; b_release = 1'b0;
      order = '{0, 1, 2, 3, 3, 2, 1, 0, 2, 0, 3, 1};
      sched = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 0};

      // Reset and defaults
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst_empty",  1024'(o_empty),    1024'(1'b1));
      chk("rst_wr_rdy", 1024'(o_wr_rdy),   1024'(4'b1111));
      chk("rst_rd_rdy", 1024'(o_rd_rdy),   1024'(1'b0));
      chk("rst_val",    1024'(o_data_val), 1024'(1'b0));
      chk("b_rst_wr",   1024'(b_wr_rdy),   1024'(2'b11));
      chk("b_rst_empty", 1024'(b_empty),   1024'(1'b1));
      pulse_req();
      chk("t1_drop", 1024'(o_req_drop), 1024'(1'b1));
      chk("t1_val",  1024'(o_data_val), 1024'(1'b0));

      // Single fill in mixed kernel order, then read
      for (int k = 0; k < NK; k++) kc[k] = 0;
      for (int i = 0; i < 12; i++) begin
         wr_word(order[i], wa(order[i], kc[order[i]]));
         kc[order[i]]++;
      end
      chk("t2_rd_rdy",  1024'(o_rd_rdy), 1024'(1'b1));
      chk("t2_wr_hold", 1024'(o_wr_rdy), 1024'(4'b0000));
      pulse_req();
      chk("t2_val",    1024'(o_data_val),   1024'(1'b1));
      chk("t2_k0",     1024'(o_data[71:0]), 1024'(72'h070809040506010203));
      chk("t2_wr_tog", 1024'(o_wr_rdy),     1024'(4'b1111));
      tick();
      chk("t2_pulse", 1024'(o_data_val), 1024'(1'b0));

      // Ping-pong: second set goes to the other bank
      fill_slots(8'hB0, 0, 2);
      chk("t3_full", 1024'(o_full), 1024'(1'b1));
      pulse_req();
      chk("t3_k0_a", 1024'(o_data[71:0]), 1024'(72'h070809040506010203));
      i_release = 1'b1;
      tick();
      i_release = 1'b0;
      chk("t3_rel_rdy",  1024'(o_rd_rdy), 1024'(1'b1));
      chk("t3_rel_full", 1024'(o_full),   1024'(1'b0));
      pulse_req();
      chk("t3_k0_b", 1024'(o_data[71:0]), 1024'(72'hB00002B00001B00000));

      // Backpressure with both banks full
      fill_slots(8'hC0, 0, 2);
      chk("t4_full",  1024'(o_full),   1024'(1'b1));
      chk("t4_no_wr", 1024'(o_wr_rdy), 1024'(4'b0000));
      fill_slots(8'hEE, 0, 1);
      i_release = 1'b1;
      tick();
      i_release = 1'b0;
      chk("t4_rel_wr0", 1024'(o_wr_rdy), 1024'(4'b0000));
      tick();
      chk("t4_rel_wr1", 1024'(o_wr_rdy), 1024'(4'b1111));
      fill_slots(8'hD0, 0, 2);
      chk("t4_full2", 1024'(o_full), 1024'(1'b1));

      // Request and release on the same edge
      i_data_req = 1'b1;
      i_release  = 1'b1;
      tick();
      i_data_req = 1'b0;
      i_release  = 1'b0;
      chk("t5_val",  1024'(o_data_val),   1024'(1'b1));
      chk("t5_k0_c", 1024'(o_data[71:0]), 1024'(72'hC00002C00001C00000));
      chk("t5_rdy",  1024'(o_rd_rdy),     1024'(1'b1));
      tick();
      pulse_req();
      chk("t5_k0_d", 1024'(o_data[71:0]), 1024'(72'hD00002D00001D00000));
      // Release on the edge where the write bank completes
      fill_slots(8'hE0, 0, 1);
      i_data_val = '1;
      for (int k = 0; k < NK; k++) i_data[k*CW +: CW] = {8'hE0, 8'(k), 8'(2)};
      i_release = 1'b1;
      tick();
      i_data_val = '0;
      i_release  = 1'b0;
      chk("t5_wr_late0", 1024'(o_wr_rdy), 1024'(4'b0000));
      chk("t5_rd_e",     1024'(o_rd_rdy), 1024'(1'b1));
      tick();
      chk("t5_wr_late1", 1024'(o_wr_rdy), 1024'(4'b1111));

      // Async reset mid-fill with a read pulse in flight
      fill_slots(8'h66, 0, 1);
      pulse_req();
      chk("t6_pre_val", 1024'(o_data_val), 1024'(1'b1));
      rst = 1'b0;
      #1;
      chk("t6_val",    1024'(o_data_val), 1024'(1'b0));
      chk("t6_data",   1024'(o_data),     1024'(0));
      chk("t6_empty",  1024'(o_empty),    1024'(1'b1));
      chk("t6_rd_rdy", 1024'(o_rd_rdy),   1024'(1'b0));
      chk("t6_wr_rdy", 1024'(o_wr_rdy),   1024'(4'b1111));
      chk("t6_full",   1024'(o_full),     1024'(1'b0));
      tick();
      rst = 1'b1;
      fill_slots(8'h5A, 0, 2);
      pulse_req();
      chk("t6_val2", 1024'(o_data_val),   1024'(1'b1));
      chk("t6_k0",   1024'(o_data[71:0]), 1024'(72'h5A00025A00015A0000));

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         i_data     = {$urandom(), $urandom(), $urandom()};
         i_data_val = 4'($urandom_range(0, 15));
         i_data_req = ($urandom_range(0, 3) == 0);
         i_release  = ($urandom_range(0, 4) == 0);
         tick();
      end
      i_data_val = '0;
      i_data_req = 1'b0;
      i_release  = 1'b0;
      tick();

      // Second parameter set: 2 kernels, 4 channels, 5 positions, 16-bit elements
      chk("b_wr_rdy0", 1024'(b_wr_rdy), 1024'(2'b11));
      exp_b = '0;
      for (int k = 0; k < BNK; k++) bkc[k] = 0;
      for (int i = 0; i < 10; i++) begin
         b_data_val = '0;
         b_data[sched[i]*BCW +: BCW] = wbk(sched[i], bkc[sched[i]]);
         exp_b[(sched[i]*BNR + bkc[sched[i]])*BCW +: BCW] = wbk(sched[i], bkc[sched[i]]);
         b_data_val[sched[i]] = 1'b1;
         tick();
         bkc[sched[i]]++;
      end
      b_data_val = '0;
      chk("b_rd_rdy", 1024'(b_rd_rdy), 1024'(1'b1));
      chk("b_wr_rdy", 1024'(b_wr_rdy), 1024'(2'b00));
      chk("b_full",   1024'(b_full),   1024'(1'b0));
      chk("b_empty",  1024'(b_empty),  1024'(1'b0));
      b_data_req = 1'b1;
      tick();
      b_data_req = 1'b0;
      chk("b_val",  1024'(b_odata_val), 1024'(1'b1));
      chk("b_data", 1024'(b_odata),     1024'(exp_b));
      chk("b_drop", 1024'(b_req_drop),  1024'(1'b0));
      tick();
      chk("b_pulse",  1024'(b_odata_val), 1024'(1'b0));
      chk("b_stable", 1024'(b_odata),     1024'(exp_b));

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
